write_bank_ctrl: RTL
====================

// Module: write_bank_ctrl
// PURPOSE
//  Sequencer for the FPU-side write bank: BANK_WIDTH byte-RAMs sharing one address and one write strobe,
//  read through a byte mux (read_sel) with 1-cycle latency. Admits filter output rows into the bank as a
//  ring buffer and drains them to the memory-write path as a serial byte stream.
//  Controls per-frame row count and signals frame completion to the top-level FSM.
// PARAMETERS
//  BANK_WIDTH             10   bytes per row (number of RAMs in bank)
//  MEM_BUFFER_DEPTH_BYTES 512  rows per RAM (ring depth); ADDR_W = $clog2(MEM_BUFFER_DEPTH_BYTES)
//  ROWS_W                 16   width of frame row counters
// PORTS
//  clk            in   1                  clock
//  rst_n          in   1                  synchronous active-low reset
//  start          in   1                  pulse: begin frame of num_rows rows (ignored while busy)
//  num_rows       in   ROWS_W             rows in frame, sampled on accepted start
//  row_valid      in   1                  producer has row on bank data_in
//  row_ready      out  1                  controller accepts row this cycle
//  bank_wr        out  1                  bank write strobe
//  bank_addr      out  ADDR_W             bank row address (shared by write and read)
//  bank_read_sel  out  $clog2(BANK_WIDTH) byte select for read
//  bank_data_out  in   8                  bank read byte, valid 1 cycle after read issue
//  out_byte       out  8                  byte to memory path
//  out_valid      out  1                  out_byte valid
//  out_ready      in   1                  consumer accepts out_byte
//  busy           out  1                  frame in progress
//  done           out  1                  1-cycle pulse: last byte of frame accepted
// BEHAVIOUR
//  Reset: all outputs 0; wr_ptr, rd_ptr, rd_sel, count, rows_in, rows_out, rd_pending cleared.
//  Reset mid-frame aborts the frame: no done, ring emptied.
//  States: IDLE -> RUN on start (num_rows latched, busy=1); RUN -> IDLE when rows_out==num_rows
//   and no byte held; done pulses on that cycle. num_rows=0: done pulses the cycle after start.
//  Write: row_ready = RUN && count<DEPTH && rows_in<num_rows (combinational).
//   On row_valid&&row_ready: bank_wr=1, bank_addr=wr_ptr, wr_ptr++ (wraps DEPTH-1->0), rows_in++, count++.
//  Read issue: permitted when RUN, count>0, !rd_pending, (!out_valid || out_ready), and no write this cycle.
//   Write has priority for the shared address. Issue drives bank_addr=rd_ptr, bank_read_sel=rd_sel,
//   sets rd_pending.
//  Capture: the cycle after issue, out_byte<=bank_data_out, out_valid<=1, rd_pending<=0.
//   If the captured byte had sel=BANK_WIDTH-1: rd_sel<=0, rd_ptr++ (wrap), count--, rows_out++.
//   Otherwise rd_sel++.
//   count decrements at capture, not issue, so a row's address is never rewritten before its last byte is read.
//  Same-cycle write accept and capture-decrement: count unchanged.
//  out_valid drops on out_ready unless a new capture occurs the same cycle. Peak rate: 1 byte / 2 cycles.
//  Byte order: row ascending, byte 0..BANK_WIDTH-1 within row.
//  bank_addr default (no write, no issue): rd_ptr. bank_read_sel default: rd_sel.
//  Full (count==DEPTH): row_ready=0. Empty: no issue. Rows beyond num_rows are never accepted.
// STRUCTURE
//  Shared package: ctrl_state_e {IDLE,RUN}.
//  Shared package: function ptr_inc(ptr, depth) for wrapping increment.
//  No sub-module; the bank itself is instantiated beside this block at the next level up.
// TESTING (bench: BANK_WIDTH=4, DEPTH=4, bank model with 1-cycle read)
//  1 Reset, then start num_rows=2, rows 0x10..13, 0x20..23, out_ready=1
//    -> bytes 10,11,12,13,20,21,22,23 in order; done pulse once; busy=0.
//  2 num_rows=6, out_ready=0 -> exactly 4 rows accepted, row_ready=0 (full).
//    Release out_ready -> remaining 2 rows accepted after wrap to addr 0,1; all 24 bytes in order.
//  3 row_valid held high continuously with out_ready=1 -> no cycle with both bank_wr and read issue;
//    byte sequence intact.
//  4 out_ready toggled 1/0 each cycle -> out_byte stable while out_valid&&!out_ready; no loss or duplication.
//  5 start with num_rows=0 -> done the next cycle.
//    start asserted while busy -> ignored, num_rows unchanged.
//  6 rst_n low after 1.5 rows drained -> next cycle all outputs 0, no done;
//    fresh start num_rows=1 completes normally from addr 0.

Source files
------------

// File: rtl/write_bank_ctrl_pkg.sv
// Shared types and helpers for the FPU-side write bank sequencer.
package write_bank_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  // Wrapping ring-pointer increment: depth-1 rolls over to 0.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/write_bank_ctrl.sv
// Write-bank sequencer: admits producer rows into a ring of byte-RAM rows and drains them
// to the memory-write path as a serial byte stream, one frame of num_rows rows at a time.
module write_bank_ctrl
  import write_bank_ctrl_pkg::*;
#(
  parameter int unsigned BANK_WIDTH             = 10,
  parameter int unsigned MEM_BUFFER_DEPTH_BYTES = 512,
  parameter int unsigned ROWS_W                 = 16,
  localparam int unsigned ADDR_W = $clog2(MEM_BUFFER_DEPTH_BYTES),
  localparam int unsigned SEL_W  = $clog2(BANK_WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ROWS_W-1:0] num_rows,
  input  logic              row_valid,
  output logic              row_ready,
  output logic              bank_wr,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [SEL_W-1:0]  bank_read_sel,
  input  logic [7:0]        bank_data_out,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(MEM_BUFFER_DEPTH_BYTES + 1);

  ctrl_state_e       state_q, state_d;
  logic [ROWS_W-1:0] num_rows_q, num_rows_d;
  logic [ROWS_W-1:0] rows_in_q, rows_in_d;
  logic [ROWS_W-1:0] rows_out_q, rows_out_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [SEL_W-1:0]  rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rd_pending_q, rd_pending_d;
  logic [7:0]        out_byte_q, out_byte_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;

  logic wr_en;
  logic rd_issue;
  logic cap_last;

  assign row_ready = (state_q == RUN) && (count_q < CNT_W'(MEM_BUFFER_DEPTH_BYTES))
                     && (rows_in_q < num_rows_q);
  assign wr_en     = row_valid && row_ready;
  // Write owns the shared address; a read waits for a write-free cycle.
  assign rd_issue  = (state_q == RUN) && (count_q != '0) && !rd_pending_q
                     && (!out_valid_q || out_ready) && !wr_en;
  assign cap_last  = rd_pending_q && (rd_sel_q == SEL_W'(BANK_WIDTH - 1));

  assign bank_wr       = wr_en;
  assign bank_addr     = wr_en ? wr_ptr_q : rd_ptr_q;
  assign bank_read_sel = rd_sel_q;
  assign out_byte      = out_byte_q;
  assign out_valid     = out_valid_q;
  assign busy          = (state_q == RUN);
  assign done          = done_q;

  always_comb begin
    state_d      = state_q;
    num_rows_d   = num_rows_q;
    rows_in_d    = rows_in_q;
    rows_out_d   = rows_out_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_sel_d     = rd_sel_q;
    count_d      = count_q;
    rd_pending_d = rd_pending_q;
    out_byte_d   = out_byte_q;
    out_valid_d  = out_valid_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_rows_d = num_rows;
          rows_in_d  = '0;
          rows_out_d = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          rd_sel_d   = '0;
          count_d    = '0;
          if (num_rows == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (wr_en) begin
          wr_ptr_d  = ADDR_W'(ptr_inc(32'(wr_ptr_q), MEM_BUFFER_DEPTH_BYTES));
          rows_in_d = rows_in_q + 1'b1;
        end

        if (rd_issue) begin
          rd_pending_d = 1'b1;
        end

        if (rd_pending_q) begin
          out_byte_d   = bank_data_out;
          out_valid_d  = 1'b1;
          rd_pending_d = 1'b0;
          if (cap_last) begin
            rd_sel_d   = '0;
            rd_ptr_d   = ADDR_W'(ptr_inc(32'(rd_ptr_q), MEM_BUFFER_DEPTH_BYTES));
            rows_out_d = rows_out_q + 1'b1;
          end else begin
            rd_sel_d = rd_sel_q + 1'b1;
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end

        // Row slot is released only once its last byte has been captured.
        case ({wr_en, cap_last})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase

        if ((rows_out_d == num_rows_q) && !out_valid_d && !rd_pending_d) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      num_rows_q   <= '0;
      rows_in_q    <= '0;
      rows_out_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_sel_q     <= '0;
      count_q      <= '0;
      rd_pending_q <= 1'b0;
      out_byte_q   <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_rows_q   <= num_rows_d;
      rows_in_q    <= rows_in_d;
      rows_out_q   <= rows_out_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_sel_q     <= rd_sel_d;
      count_q      <= count_d;
      rd_pending_q <= rd_pending_d;
      out_byte_q   <= out_byte_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
    end
  end

endmodule
